// File: rtl/rip_csr_unit.sv
// rip_csr_unit: machine-mode CSR responder for the rip core.
// Holds mstatus/mtvec/mepc/mcause, the free-running cycle counter and the
// read-only branch-prediction statistics counters; executes CSRRW/RS/RC and
// their immediate forms from EX and redirects on ECALL/MRET.
// Build option: define RIP_BP_STATS_EN to enable the bptp/bptn/bpfp/bpfn
// counters; without it they read as constant 0 and the bp_* inputs are ignored.

package rip_type;

    typedef struct packed {
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] cycle;
        logic [31:0] bptp;
        logic [31:0] bptn;
        logic [31:0] bpfp;
        logic [31:0] bpfn;
    } csr_t;

endpackage

module rip_csr_unit #(
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
    parameter logic [31:0] MSTATUS_RESET = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                csr_valid,
    input  logic [2:0]          csr_funct3,
    input  logic [11:0]         csr_addr,
    input  logic [4:0]          csr_rs1,
    input  logic [31:0]         csr_wdata,
    output logic [31:0]         csr_rdata,
    output logic                csr_rvalid,
    output logic                csr_illegal,
    input  logic                ecall,
    input  logic                mret,
    input  logic [31:0]         trap_pc,
    output logic                trap_req,
    output logic [31:0]         trap_target,
    input  logic                bp_valid,
    input  logic                bp_pred_taken,
    input  logic                bp_actual_taken,
    output rip_type::csr_t      csr
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_CYCLE   = 12'hC00;
    localparam logic [11:0] ADDR_BPTP    = 12'hCC0;
    localparam logic [11:0] ADDR_BPTN    = 12'hCC1;
    localparam logic [11:0] ADDR_BPFP    = 12'hCC2;
    localparam logic [11:0] ADDR_BPFN    = 12'hCC3;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] ALIGN_MASK     = ~32'h3;
    localparam int          MIE_BIT        = 3;
    localparam int          MPIE_BIT       = 7;

    // Low two funct3 bits select the operation; bit 2 selects the zimm source.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mtvec_q,   mtvec_d;
    logic [31:0] mepc_q,    mepc_d;
    logic [31:0] mcause_q,  mcause_d;
    logic [31:0] cycle_q;
    logic [31:0] bptp_q, bptn_q, bpfp_q, bpfn_q;

    logic [31:0] csr_rdata_q;
    logic        csr_rvalid_q;
    logic        csr_illegal_q;
    logic        trap_req_q;
    logic [31:0] trap_target_q;

    csr_op_e     op;
    logic        take_ecall, take_mret, take_csr;
    logic [31:0] src, old_val, new_val;
    logic        addr_ok, addr_ro, wr_en, illegal, do_write;

    // Priority ecall > mret > csr request; everything is frozen by stall.
    assign take_ecall = ecall & ~stall;
    assign take_mret  = mret & ~stall & ~ecall;
    assign take_csr   = csr_valid & ~stall & ~ecall & ~mret;

    assign op    = csr_op_e'(csr_funct3[1:0]);
    assign src   = csr_funct3[2] ? {27'b0, csr_rs1} : csr_wdata;
    assign wr_en = (op == OP_RW) || (csr_rs1 != 5'd0);

    // Address decode: old value, legality and read-only attribute.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        old_val = '0;
        addr_ok = 1'b0;
        addr_ro = 1'b0;
        case (csr_addr)
            ADDR_MSTATUS: begin old_val = mstatus_q; addr_ok = 1'b1; end
            ADDR_MTVEC:   begin old_val = mtvec_q;   addr_ok = 1'b1; end
            ADDR_MEPC:    begin old_val = mepc_q;    addr_ok = 1'b1; end
            ADDR_MCAUSE:  begin old_val = mcause_q;  addr_ok = 1'b1; end
            ADDR_CYCLE:   begin old_val = cycle_q;   addr_ok = 1'b1; addr_ro = 1'b1; end
            ADDR_BPTP:    begin old_val = bptp_q;    addr_ok = 1'b1; addr_ro = 1'b1; end
            ADDR_BPTN:    begin old_val = bptn_q;    addr_ok = 1'b1; addr_ro = 1'b1; end
            ADDR_BPFP:    begin old_val = bpfp_q;    addr_ok = 1'b1; addr_ro = 1'b1; end
            ADDR_BPFN:    begin old_val = bpfn_q;    addr_ok = 1'b1; addr_ro = 1'b1; end
            default:      ;
        endcase
    end

    assign illegal  = (op == OP_NONE) || !addr_ok || (wr_en && addr_ro);
    assign do_write = take_csr && !illegal && wr_en;

    // Read-modify-write result of the CSR instruction.
    always_comb begin
        new_val = old_val;
        case (op)
            OP_RW:   new_val = src;
            OP_RS:   new_val = old_val | src;
            OP_RC:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end

    // Next architectural state: trap entry/return outrank instruction writes.
    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (take_ecall) begin
            mepc_d              = trap_pc & ALIGN_MASK;
            mcause_d            = MCAUSE_ECALL_M;
            mstatus_d[MPIE_BIT] = mstatus_q[MIE_BIT];
            mstatus_d[MIE_BIT]  = 1'b0;
        end else if (take_mret) begin
            mstatus_d[MIE_BIT]  = mstatus_q[MPIE_BIT];
            mstatus_d[MPIE_BIT] = 1'b1;
        end else if (do_write) begin
            case (csr_addr)
                ADDR_MSTATUS: mstatus_d = new_val;
                ADDR_MTVEC:   mtvec_d   = new_val & ALIGN_MASK;
                ADDR_MEPC:    mepc_d    = new_val & ALIGN_MASK;
                ADDR_MCAUSE:  mcause_d  = new_val;
                default:      ;
            endcase
        end
    end

    // Architectural CSR registers and the free-running cycle counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
        if (rst) begin
            mstatus_q <= MSTATUS_RESET;
            mtvec_q   <= MTVEC_RESET & ALIGN_MASK;
            mepc_q    <= '0;
            mcause_q  <= '0;
            cycle_q   <= '0;
        end else begin
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            cycle_q   <= cycle_q + 32'd1;
        end
    end

`ifdef RIP_BP_STATS_EN
    logic bp_fire;
    assign bp_fire = bp_valid & ~stall;

    // Saturating branch-prediction outcome counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            bptp_q <= '0;
            bptn_q <= '0;
            bpfp_q <= '0;
            bpfn_q <= '0;
        end else if (bp_fire) begin
            case ({bp_pred_taken, bp_actual_taken})
                2'b11:   if (bptp_q != '1) bptp_q <= bptp_q + 32'd1;
                2'b00:   if (bptn_q != '1) bptn_q <= bptn_q + 32'd1;
                2'b10:   if (bpfp_q != '1) bpfp_q <= bpfp_q + 32'd1;
                default: if (bpfn_q != '1) bpfn_q <= bpfn_q + 32'd1;
            endcase
        end
    end
`else
    logic unused_bp_inputs;
    assign unused_bp_inputs = ^{bp_valid, bp_pred_taken, bp_actual_taken};
    assign bptp_q = '0;
    assign bptn_q = '0;
    assign bpfp_q = '0;
    assign bpfn_q = '0;
`endif

    // Registered response pulses; reset clears anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_rdata_q   <= '0;
            csr_rvalid_q  <= 1'b0;
            csr_illegal_q <= 1'b0;
            trap_req_q    <= 1'b0;
            trap_target_q <= '0;
        end else begin
            csr_rvalid_q  <= take_csr;
            csr_illegal_q <= take_csr && illegal;
            csr_rdata_q   <= (take_csr && !illegal) ? old_val : '0;
            trap_req_q    <= take_ecall || take_mret;
            trap_target_q <= take_ecall ? mtvec_q : (take_mret ? mepc_q : '0);
        end
    end

    assign csr_rdata   = csr_rdata_q;
    assign csr_rvalid  = csr_rvalid_q;
    assign csr_illegal = csr_illegal_q;
    assign trap_req    = trap_req_q;
    assign trap_target = trap_target_q;

    assign csr = '{mstatus: mstatus_q, mtvec: mtvec_q, mepc: mepc_q,
                   mcause: mcause_q, cycle: cycle_q, bptp: bptp_q,
                   bptn: bptn_q, bpfp: bpfp_q, bpfn: bpfn_q};

endmodule

// File: tb/tb_rip_csr_unit.sv
// Testbench for rip_csr_unit: directed steps plus a randomized run, all
// checked against an address-indexed reference model of the CSR file.
module tb_rip_csr_unit;
    import rip_type::*;

    localparam logic [31:0] MTVEC_R   = 32'h0000_1003;
    localparam logic [31:0] MSTATUS_R = 32'h0000_1800;

    logic        clk = 1'b0;
    logic        rst, stall, csr_valid, ecall, mret;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [4:0]  csr_rs1;
    logic [31:0] csr_wdata, trap_pc;
    logic        bp_valid, bp_pred_taken, bp_actual_taken;
    logic [31:0] csr_rdata, trap_target;
    logic        csr_rvalid, csr_illegal, trap_req;
    csr_t        csr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rip_csr_unit #(.MTVEC_RESET(MTVEC_R), .MSTATUS_RESET(MSTATUS_R)) dut (
        .clk(clk), .rst(rst), .stall(stall), .csr_valid(csr_valid),
        .csr_funct3(csr_funct3), .csr_addr(csr_addr), .csr_rs1(csr_rs1),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
        .csr_illegal(csr_illegal), .ecall(ecall), .mret(mret), .trap_pc(trap_pc),
        .trap_req(trap_req), .trap_target(trap_target), .bp_valid(bp_valid),
        .bp_pred_taken(bp_pred_taken), .bp_actual_taken(bp_actual_taken), .csr(csr)
    );

    typedef struct {
        bit          rst, stall, valid, ecall, mret, bv, bp, ba;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  rs1;
        logic [31:0] wd, tpc;
    } req_t;

    // Reference model: CSR file as a map from address to value.
    logic [31:0] m [int unsigned];

    function automatic req_t idle();
        req_t r;
        r.rst = 0; r.stall = 0; r.valid = 0; r.ecall = 0; r.mret = 0;
        r.bv = 0; r.bp = 0; r.ba = 0; r.f3 = 3'd0; r.addr = 12'd0;
        r.rs1 = 5'd0; r.wd = 32'd0; r.tpc = 32'd0;
        return r;
    endfunction

    task automatic model_reset();
        m.delete();
        m['h300] = MSTATUS_R;
        m['h305] = MTVEC_R & ~32'h3;
        m['h341] = 0; m['h342] = 0; m['hC00] = 0;
        m['hCC0] = 0; m['hCC1] = 0; m['hCC2] = 0; m['hCC3] = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, compare after the edge.
    task automatic step(input req_t r, input string tag);
        bit          e_rv, e_il, e_tr;
        logic [31:0] e_rd, e_tt, src, nv, ms;
        int unsigned a;
        bit          wen, legal;

        rst = r.rst; stall = r.stall; csr_valid = r.valid; csr_funct3 = r.f3;
        csr_addr = r.addr; csr_rs1 = r.rs1; csr_wdata = r.wd; ecall = r.ecall;
        mret = r.mret; trap_pc = r.tpc; bp_valid = r.bv;
        bp_pred_taken = r.bp; bp_actual_taken = r.ba;

        e_rv = 0; e_il = 0; e_tr = 0; e_rd = 0; e_tt = 0;
        if (r.rst) begin
            model_reset();
        end else begin
            if (!r.stall) begin
                if (r.ecall) begin
                    e_tr = 1; e_tt = m['h305];
                    m['h341] = r.tpc & ~32'h3;
                    m['h342] = 32'd11;
                    ms = m['h300];
                    ms[7] = ms[3]; ms[3] = 1'b0;
                    m['h300] = ms;
                end else if (r.mret) begin
                    e_tr = 1; e_tt = m['h341];
                    ms = m['h300];
                    ms[3] = ms[7]; ms[7] = 1'b1;
                    m['h300] = ms;
                end else if (r.valid) begin
                    a = r.addr;
                    e_rv = 1;
                    src = r.f3[2] ? {27'd0, r.rs1} : r.wd;
                    wen = (r.f3[1:0] == 2'b01) || (r.rs1 != 0);
                    legal = (r.f3[1:0] != 2'b00) && m.exists(a) && !(wen && a >= 'hC00);
                    if (legal) begin
                        e_rd = m[a];
                        if (wen) begin
                            if (r.f3[1:0] == 2'b01)      nv = src;
                            else if (r.f3[1:0] == 2'b10) nv = m[a] | src;
                            else                         nv = m[a] & ~src;
                            if (a == 'h305 || a == 'h341) nv = nv & ~32'h3;
                            m[a] = nv;
                        end
                    end else begin
                        e_il = 1;
                    end
                end
`ifdef RIP_BP_STATS_EN
                if (r.bv) begin
                    a = r.bp ? (r.ba ? 'hCC0 : 'hCC2) : (r.ba ? 'hCC3 : 'hCC1);
                    if (m[a] != 32'hFFFF_FFFF) m[a] = m[a] + 1;
                end
`endif
            end
            m['hC00] = m['hC00] + 32'd1;
        end

        @(posedge clk);
        #1;
        check({tag, ".rvalid"},   {31'd0, csr_rvalid},  {31'd0, e_rv});
        check({tag, ".illegal"},  {31'd0, csr_illegal}, {31'd0, e_il});
        check({tag, ".trap_req"}, {31'd0, trap_req},    {31'd0, e_tr});
        if (e_rv || r.rst) check({tag, ".rdata"},  csr_rdata,   e_rd);
        if (e_tr || r.rst) check({tag, ".target"}, trap_target, e_tt);
        check({tag, ".mstatus"}, csr.mstatus, m['h300]);
        check({tag, ".mtvec"},   csr.mtvec,   m['h305]);
        check({tag, ".mepc"},    csr.mepc,    m['h341]);
        check({tag, ".mcause"},  csr.mcause,  m['h342]);
        check({tag, ".cycle"},   csr.cycle,   m['hC00]);
        check({tag, ".bptp"},    csr.bptp,    m['hCC0]);
        check({tag, ".bptn"},    csr.bptn,    m['hCC1]);
        check({tag, ".bpfp"},    csr.bpfp,    m['hCC2]);
        check({tag, ".bpfn"},    csr.bpfn,    m['hCC3]);
    endtask

    initial begin
        req_t        r;
        logic [11:0] addr_tab [9];
        addr_tab = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hC00,
                     12'hCC0, 12'hCC1, 12'hCC2, 12'hCC3};

        // Reset
        r = idle(); r.rst = 1;
        step(r, "reset0");
        step(r, "reset1");

        // CSRRW mtvec returns reset value, stores aligned value
        r = idle(); r.valid = 1; r.f3 = 3'b001; r.addr = 12'h305; r.wd = 32'h8000_0107; r.rs1 = 5'd3;
        step(r, "rw_mtvec");
        check("rw_mtvec.literal", csr.mtvec, 32'h8000_0104);

        // CSRRS rs1=0 reads without writing; cycle readable; write to cycle illegal
        r = idle(); r.valid = 1; r.f3 = 3'b010; r.addr = 12'h300; r.wd = 32'hFFFF_FFFF;
        step(r, "rs_mstatus_rs0");
        r.addr = 12'hC00;
        step(r, "rs_cycle_rs0");
        r = idle(); r.valid = 1; r.f3 = 3'b101; r.addr = 12'hC00; r.rs1 = 5'd5;
        step(r, "rwi_cycle");
        check("rwi_cycle.rdata_zero", csr_rdata, 32'd0);

        // Bad funct3 and unmapped address
        r = idle(); r.valid = 1; r.f3 = 3'b000; r.addr = 12'h300;
        step(r, "f3_000");
        r.f3 = 3'b100;
        step(r, "f3_100");
        r = idle(); r.valid = 1; r.f3 = 3'b010; r.addr = 12'h123;
        step(r, "unmapped");
        r = idle(); r.valid = 1; r.f3 = 3'b110; r.addr = 12'hCC0; r.rs1 = 5'd1;
        step(r, "rsi_bptp_ro");
        r = idle(); r.valid = 1; r.f3 = 3'b111; r.addr = 12'hCC2;
        step(r, "rci_bpfp_read");

        // ECALL entry
        r = idle(); r.valid = 1; r.f3 = 3'b001; r.addr = 12'h300; r.wd = 32'h8;
        step(r, "set_mstatus");
        r.addr = 12'h305; r.wd = 32'h100;
        step(r, "set_mtvec");
        r = idle(); r.ecall = 1; r.tpc = 32'h2002;
        step(r, "ecall");
        check("ecall.target_lit",  trap_target, 32'h100);
        check("ecall.mepc_lit",    csr.mepc,    32'h2000);
        check("ecall.mcause_lit",  csr.mcause,  32'd11);
        check("ecall.mstatus_lit", csr.mstatus, 32'h80);

        // ecall beats mret and csr request, then mret alone restores MIE
        r = idle(); r.valid = 1; r.f3 = 3'b001; r.addr = 12'h300; r.wd = 32'h8;
        step(r, "set_mie");
        r = idle(); r.ecall = 1; r.mret = 1; r.valid = 1; r.f3 = 3'b001;
        r.addr = 12'h342; r.wd = 32'h55; r.tpc = 32'h3000;
        step(r, "ecall_prio");
        r = idle(); r.mret = 1; r.valid = 1; r.f3 = 3'b001; r.addr = 12'h342; r.wd = 32'h77;
        step(r, "mret_prio");
        check("mret.mie", {31'd0, csr.mstatus[3]}, 32'd1);
        r = idle(); r.mret = 1;
        step(r, "mret_alone");

        // Branch statistics
        for (int i = 0; i < 12; i++) begin
            r = idle(); r.bv = 1; r.bp = i[0]; r.ba = i[1];
            r.valid = 1; r.f3 = 3'b010; r.addr = 12'hCC0 + 12'(i % 4);
            step(r, "bp_seq");
        end
`ifndef RIP_BP_STATS_EN
        check("bp_off.bptp", csr.bptp, 32'd0);
`else
        force dut.bpfn_q = 32'hFFFF_FFFE;
        #1;
        release dut.bpfn_q;
        m['hCC3] = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            r = idle(); r.bv = 1; r.bp = 0; r.ba = 1;
            step(r, "bpfn_sat");
        end
        r = idle(); r.valid = 1; r.f3 = 3'b010; r.addr = 12'hCC3;
        step(r, "bpfn_read");
        check("bpfn.sat_lit", csr_rdata, 32'hFFFF_FFFF);
`endif

        // Stall freezes everything except cycle
        r = idle(); r.stall = 1; r.valid = 1; r.f3 = 3'b001; r.addr = 12'h341;
        r.wd = 32'h1234; r.ecall = 1; r.bv = 1; r.bp = 1; r.ba = 1;
        step(r, "stall_all");

        // Cycle wrap
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        m['hC00] = 32'hFFFF_FFFF;
        step(idle(), "cycle_wrap");
        check("cycle_wrap.lit", csr.cycle, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = idle();
            r.stall = ($urandom_range(0, 4) == 0);
            r.valid = ($urandom_range(0, 3) != 0);
            r.ecall = ($urandom_range(0, 9) == 0);
            r.mret  = ($urandom_range(0, 9) == 0);
            r.f3    = 3'($urandom_range(0, 7));
            r.addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 8)];
            r.rs1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            r.wd    = $urandom;
            r.tpc   = $urandom;
            r.bv    = 1'($urandom);
            r.bp    = 1'($urandom);
            r.ba    = 1'($urandom);
            step(r, "rand");
        end

        // Reset coinciding with an ECALL leaves no pulse
        r = idle(); r.rst = 1; r.ecall = 1; r.tpc = 32'h4000;
        step(r, "rst_ecall");
        step(idle(), "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
